// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle ARM control unit: state encoding,
// datapath mux-select constants, ALU operation codes and the data-processing
// cmd decoder used by the control FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // ALU operations
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_EOR = 4'd4;
  localparam logic [3:0] ALU_MOV = 4'd5;

  // Mux selects
  localparam logic       SRCA_RN       = 1'b0;
  localparam logic       SRCA_PC       = 1'b1;
  localparam logic [1:0] SRCB_RM       = 2'd0;
  localparam logic [1:0] SRCB_IMM      = 2'd1;
  localparam logic [1:0] SRCB_FOUR     = 2'd2;
  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;

  // Data-processing cmd field, Instr[24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  typedef struct packed {
    logic [3:0] alu;    // ALU operation for EXEC
    logic       wr_rd;  // cmd writes Rd (goes through ALUWB)
    logic       supp;   // supported cmd: may update NZ
    logic       cv;     // arithmetic cmd: may also update CV
  } cmd_dec_t;

  // Unsupported cmds decode as a NOP: ADD on the ALU, nothing written.
  function automatic cmd_dec_t cmd_decode(input logic [3:0] cmd);
    cmd_dec_t d;
    d = '{alu: ALU_ADD, wr_rd: 1'b0, supp: 1'b0, cv: 1'b0};
    case (cmd)
      CMD_AND: d = '{alu: ALU_AND, wr_rd: 1'b1, supp: 1'b1, cv: 1'b0};
      CMD_EOR: d = '{alu: ALU_EOR, wr_rd: 1'b1, supp: 1'b1, cv: 1'b0};
      CMD_SUB: d = '{alu: ALU_SUB, wr_rd: 1'b1, supp: 1'b1, cv: 1'b1};
      CMD_ADD: d = '{alu: ALU_ADD, wr_rd: 1'b1, supp: 1'b1, cv: 1'b1};
      CMD_ORR: d = '{alu: ALU_ORR, wr_rd: 1'b1, supp: 1'b1, cv: 1'b0};
      CMD_MOV: d = '{alu: ALU_MOV, wr_rd: 1'b1, supp: 1'b1, cv: 1'b0};
      CMD_CMP: d = '{alu: ALU_SUB, wr_rd: 1'b0, supp: 1'b1, cv: 1'b1};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_control_fsm_cond_unit.sv
// ARM condition-code evaluator.
//   cond   : Instr[31:28]
//   flags  : architectural {N,Z,C,V}
//   condex : 1 when the instruction should execute (1111 = never)
module cond_unit (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b0;
    case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle ARM control unit. Moore FSM sequencing a shared ALU / shared
// memory datapath through FETCH, DECODE, EXEC/MEM and writeback; also holds
// the NZCV flags register and evaluates condition codes.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   Instr           : instruction register output
//   ALUFlags        : {N,Z,C,V} from the ALU this cycle
//   Adr             : low data-address bits for byte enables
//   PCWrite/IRWrite/RegWrite/MemWrite : write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc : datapath selects
//   FlagWrite       : {NZ, CV} flag update strobes
//   be              : byte enables
//   state           : current state register (debug)
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  Adr,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  FlagWrite,
  output logic [3:0]  be,
  output logic [3:0]  state
);

  state_t     st, st_nxt, ost;
  logic [3:0] flags;
  logic       condex;
  cmd_dec_t   cd;
  logic [1:0] op;
  logic       rd_pc;
  logic       unused_instr;

  assign op           = Instr[27:26];
  assign cd           = cmd_decode(Instr[24:21]);
  assign rd_pc        = (Instr[15:12] == 4'd15);
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};
  assign state        = st;

  cond_unit u_cond (
    .cond   (Instr[31:28]),
    .flags  (flags),
    .condex (condex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= FETCH;
      flags <= 4'b0000;
    end else begin
      st <= st_nxt;
      if (FlagWrite[1]) flags[3:2] <= ALUFlags[3:2];
      if (FlagWrite[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    st_nxt = FETCH;
    case (st)
      FETCH:  st_nxt = DECODE;
      DECODE: begin
        if (condex) begin
          case (op)
            2'b00:   st_nxt = Instr[25] ? EXECI : EXECR;
            2'b01:   st_nxt = MEMADR;
            2'b10:   st_nxt = BRANCH;
            default: st_nxt = FETCH;
          endcase
        end
      end
      MEMADR:       st_nxt = Instr[20] ? MEMRD : MEMWR;
      MEMRD:        st_nxt = MEMWB;
      EXECR, EXECI: st_nxt = cd.wr_rd ? ALUWB : FETCH;
      default:      st_nxt = FETCH;
    endcase
  end

  // Outputs decode from state and Instr only; during reset the datapath sees
  // FETCH selects with every write enable held low.
  always_comb begin
    ost        = reset ? FETCH : st;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_RN;
    ALUSrcB    = SRCB_RM;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    FlagWrite  = 2'b00;
    be         = 4'b1111;
    ImmSrc     = Instr[27:26];
    RegSrc     = {(op == 2'b01) && !Instr[20], op == 2'b10};
    case (ost)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (Instr[22]) be = 4'b0001 << Adr;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        PCWrite   = rd_pc;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (Instr[22]) be = 4'b0001 << Adr;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (ost == EXECI) ? SRCB_IMM : SRCB_RM;
        ALUControl = cd.alu;
        if (Instr[20] && cd.supp) FlagWrite = {1'b1, cd.cv};
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        PCWrite   = rd_pc;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      FlagWrite = 2'b00;
    end
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control unit for the ARM core: a Moore state machine that sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback. Each instruction takes 2–5 cycles instead of one. The block replaces the single-cycle `controller` when the core is built in multicycle form. It holds the architectural NZCV flags and evaluates condition codes, then drives every mux select and write enable of the datapath.

## Interface
Parameters: none.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- Instr  in  32  instruction-register output; changes only on the edge that ends FETCH
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- Adr  in  2  low bits of the registered data address, used for byte enables
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- ALUSrcA  out  1  ALU A select: 0=Rn register, 1=PC
- ALUSrcB  out  2  ALU B select: 0=Rm register, 1=ExtImm, 2=constant 4
- ResultSrc  out  2  result select: 0=ALUOut, 1=Data, 2=ALUResult
- ALUControl  out  4  ALU operation: ADD=0, SUB=1, AND=2, ORR=3, EOR=4, MOV(pass B)=5
- ImmSrc  out  2  equals Instr[27:26]
- RegSrc  out  2  bit0=(Op==10), bit1=(Op==01 && L==0)
- FlagWrite  out  2  to the datapath; bit1 = NZ, bit0 = CV
- be  out  4  byte enables
- state  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH → DECODE, unconditionally.
- DECODE transitions:
  - CondEx=0 → FETCH.
  - Op=00: Instr[25] ? EXECI : EXECR.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH (undefined opcode, no effect).
- MEMADR: Instr[20] (L) ? MEMRD : MEMWR.
- MEMRD → MEMWB → FETCH.
- MEMWR → FETCH.
- EXECR/EXECI → ALUWB if the cmd writes Rd, else FETCH.
- ALUWB → FETCH.
- BRANCH → FETCH. The L bit is ignored; BL behaves as B.
- Per-state outputs (anything not listed is 0):
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2.
  - DECODE: ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2 (produces PC+8).
  - MEMADR: ALUSrcB=1. ALU op is ADD if Instr[23] (U)=1, else SUB.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=1, RegWrite=1, PCWrite=(Rd==15).
  - MEMWR: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcB=0, ALU op from cmd.
  - EXECI: ALUSrcB=1, ALU op from cmd.
  - ALUWB: ResultSrc=0, RegWrite=1, PCWrite=(Rd==15).
  - BRANCH: ALUSrcB=1, ADD, ResultSrc=2, PCWrite=1.
- Cmd decode (Instr[24:21]):
  - AND 0000 → AND; EOR 0001 → EOR; SUB 0010 → SUB; ADD 0100 → ADD; ORR 1100 → ORR; MOV 1101 → MOV. Each of these writes Rd.
  - CMP 1010 → SUB, no Rd write.
  - Any other cmd executes as a NOP: no Rd write, no flag write.
- FlagWrite is asserted only in EXECR/EXECI, only when S (Instr[20])=1:
  - bit1 for every supported cmd.
  - bit0 only for ADD/SUB/CMP.
- Internal flags register: on the same edge, NZ ← ALUFlags[3:2] if FlagWrite[1]; CV ← ALUFlags[1:0] if FlagWrite[0].
- CondEx is combinational from Instr[31:28] and the flags register, using the ARM condition table (EQ…AL). Cond 1111 is treated as never.
- Byte enables:
  - In MEMRD/MEMWR with Instr[22] (B)=1: be = 4'b0001 << Adr.
  - Otherwise be = 4'b1111.

## Timing
- Reset:
  - While reset=1, all write enables (PCWrite, IRWrite, RegWrite, MemWrite, FlagWrite) are forced to 0.
  - At the next edge, state ← FETCH and flags ← 0000.
  - Other outputs show FETCH values during reset.
- Reset mid-instruction aborts at the next edge with no further writes.
- Cycle counts per instruction:
  - LDR: 5
  - STR/STRB: 4
  - Data-processing with Rd write: 4
  - CMP / NOP cmd: 3
  - B: 3
  - Failed condition or Op=11: 2
- Flags written at the end of EXEC are visible to CondEx in the next instruction's DECODE.
- All outputs are functions of state and Instr only. There is no combinational path from ALUFlags to any output.

## Structure
- Package `mc_pkg`:
  - state enum (4-bit),
  - ALUControl constants,
  - ALUSrcA/ALUSrcB/ResultSrc select constants,
  - cmd encodings.
- Sub-module `cond_unit`: combinational cond × NZCV → CondEx.
- Top level holds the state register, the flags register and the per-state output decode.

## Test plan
- Hold reset for 3 cycles: PCWrite=IRWrite=RegWrite=MemWrite=0 throughout. First cycle after release: state=FETCH, IRWrite=1, PCWrite=1, ALUSrcB=2.
- 0xE0821003 (ADD R1,R2,R3):
  - Sequence FETCH, DECODE, EXECR, ALUWB.
  - ALUControl=0 in EXECR.
  - RegWrite=1 only in ALUWB; PCWrite=0 there.
- SUBS 0xE2511001 with ALUFlags=0110:
  - FlagWrite=11 in EXECI.
  - Then 0x0A000002 (BEQ) enters BRANCH with PCWrite=1.
  - Repeat with ALUFlags=0000: BEQ returns to FETCH after DECODE (2 cycles).
- 0xE5910004 (LDR):
  - 5-state sequence; ALUControl=ADD in MEMADR.
  - MEMWB has ResultSrc=1 and RegWrite=1.
  - 0xE5110004 gives ALUControl=SUB in MEMADR.
- 0xE5C10001 (STRB) with Adr=01: MEMWR asserts MemWrite=1 and be=0010. Word STR gives be=1111.
- 0xE1510002 (CMP): EXECR → FETCH with RegWrite never 1. Assert reset during MEMRD of an LDR: state=FETCH next cycle and MEMWB never occurs.
